// File: rtl/power_seq_pkg.sv
// Shared definitions for the board supply sequencer: state encodings, default
// timing constants and the state-to-rail-enable decode.
package power_seq_pkg;

  localparam int DEF_DUTY_W        = 4;
  localparam int DEF_STEP_CYCLES   = 4;
  localparam int DEF_PG_TIMEOUT    = 32;
  localparam int DEF_LDO_DELAY     = 8;
  localparam int DEF_HICCUP_CYCLES = 16;
  localparam int DEF_MAX_RETRIES   = 3;

  localparam logic [2:0] ST_OFF       = 3'd0;
  localparam logic [2:0] ST_SOFTSTART = 3'd1;
  localparam logic [2:0] ST_WAIT_PG   = 3'd2;
  localparam logic [2:0] ST_LDO_ON    = 3'd3;
  localparam logic [2:0] ST_RUN       = 3'd4;
  localparam logic [2:0] ST_HICCUP    = 3'd5;
  localparam logic [2:0] ST_LATCHED   = 3'd6;

  typedef enum logic [2:0] {
    S_OFF       = ST_OFF,
    S_SOFTSTART = ST_SOFTSTART,
    S_WAIT_PG   = ST_WAIT_PG,
    S_LDO_ON    = ST_LDO_ON,
    S_RUN       = ST_RUN,
    S_HICCUP    = ST_HICCUP,
    S_LATCHED   = ST_LATCHED
  } seq_state_e;

  typedef struct packed {
    logic buck_en;
    logic ldo_en;
    logic pwr_good;
    logic fault_latched;
  } rail_ctrl_t;

  // Counter width able to hold 0 .. max_count-1 (at least one bit).
  function automatic int ctr_width(input int max_count);
    return (max_count > 1) ? $clog2(max_count) : 1;
  endfunction

  function automatic rail_ctrl_t decode_rails(input seq_state_e st);
    rail_ctrl_t r;
    r = '0;
    case (st)
      S_SOFTSTART, S_WAIT_PG: r.buck_en = 1'b1;
      S_LDO_ON: begin
        r.buck_en = 1'b1;
        r.ldo_en  = 1'b1;
      end
      S_RUN: begin
        r.buck_en  = 1'b1;
        r.ldo_en   = 1'b1;
        r.pwr_good = 1'b1;
      end
      S_LATCHED: r.fault_latched = 1'b1;
      default: ;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/soft_start_ramp.sv
// Soft-start duty ramp: a STEP_CYCLES prescaler feeding a saturating duty
// counter; done flags the edge on which the duty reaches full scale.
module soft_start_ramp
  import power_seq_pkg::*;
#(
  parameter int DUTY_W      = DEF_DUTY_W,
  parameter int STEP_CYCLES = DEF_STEP_CYCLES
) (
  input  logic              clk,
  input  logic              por,
  input  logic              clear,
  input  logic              run,
  output logic [DUTY_W-1:0] duty,
  output logic              done
);

  localparam int                PRE_W    = ctr_width(STEP_CYCLES);
  localparam logic [PRE_W-1:0]  PRE_LAST = PRE_W'(STEP_CYCLES - 1);
  localparam logic [DUTY_W-1:0] DUTY_MAX = {DUTY_W{1'b1}};

  logic [PRE_W-1:0] pre;
  logic             step;

  assign step = run && (pre == PRE_LAST);
  // Asserted on the edge that moves duty to full scale, so the owner can
  // change state on that same edge.
  assign done = step && (duty == DUTY_MAX - 1'b1);

  always_ff @(posedge clk or posedge por) begin
    if (por) begin
      pre  <= '0;
      duty <= '0;
    end else if (clear) begin
      pre  <= '0;
      duty <= '0;
    end else if (run) begin
      // NOTE: non-blocking assignments make pre and duty both update from
      // their pre-edge values, which the step decode relies on.
      pre <= step ? '0 : pre + 1'b1;
      if (step && (duty != DUTY_MAX)) begin
        duty <= duty + 1'b1;
      end
    end
  end

endmodule

// File: rtl/power_sequencer.sv
// Buck + LDO supply sequencer: soft-start, power-good qualification, LDO
// enable delay, hiccup auto-retry and latch-off after repeated faults.
module power_sequencer
  import power_seq_pkg::*;
#(
  parameter int DUTY_W        = DEF_DUTY_W,
  parameter int STEP_CYCLES   = DEF_STEP_CYCLES,
  parameter int PG_TIMEOUT    = DEF_PG_TIMEOUT,
  parameter int LDO_DELAY     = DEF_LDO_DELAY,
  parameter int HICCUP_CYCLES = DEF_HICCUP_CYCLES,
  parameter int MAX_RETRIES   = DEF_MAX_RETRIES
) (
  input  logic              clk,
  input  logic              por,
  input  logic              sw_sig,
  input  logic              ocp_trigger,
  input  logic              buck_pgood,
  output logic              buck_en,
  output logic [DUTY_W-1:0] duty_limit,
  output logic              ldo_en,
  output logic              pwr_good,
  output logic              pwr_dis,
  output logic              fault_latched,
  output logic [1:0]        retry_cnt
);

  localparam int CNT_MAX_A = (PG_TIMEOUT > LDO_DELAY) ? PG_TIMEOUT : LDO_DELAY;
  localparam int CNT_MAX   = (CNT_MAX_A > HICCUP_CYCLES) ? CNT_MAX_A : HICCUP_CYCLES;
  localparam int CNT_W     = ctr_width(CNT_MAX);

  localparam logic [CNT_W-1:0]  PG_LAST   = CNT_W'(PG_TIMEOUT - 1);
  localparam logic [CNT_W-1:0]  LDO_LAST  = CNT_W'(LDO_DELAY - 1);
  localparam logic [CNT_W-1:0]  HIC_LAST  = CNT_W'(HICCUP_CYCLES - 1);
  localparam logic [1:0]        RETRY_MAX = 2'(MAX_RETRIES);
  localparam logic [DUTY_W-1:0] DUTY_MAX  = {DUTY_W{1'b1}};

  seq_state_e        state;
  logic [CNT_W-1:0]  cnt;
  logic [DUTY_W-1:0] ramp_duty;
  logic              ramp_done;
  logic              fault;
  logic [1:0]        retry_next;
  rail_ctrl_t        rails;

  soft_start_ramp #(
    .DUTY_W      (DUTY_W),
    .STEP_CYCLES (STEP_CYCLES)
  ) u_ramp (
    .clk   (clk),
    .por   (por),
    .clear (state != S_SOFTSTART),
    .run   (state == S_SOFTSTART),
    .duty  (ramp_duty),
    .done  (ramp_done)
  );

  always_comb begin
    // NOTE: fault gets a value before the case so no path leaves it unassigned
    // and no latch is inferred.
    fault = 1'b0;
    case (state)
      S_SOFTSTART:     fault = ocp_trigger;
      S_WAIT_PG:       fault = ocp_trigger || (!buck_pgood && (cnt == PG_LAST));
      S_LDO_ON, S_RUN: fault = ocp_trigger || !buck_pgood;
      default:         fault = 1'b0;
    endcase
  end

  assign retry_next = (retry_cnt == RETRY_MAX) ? retry_cnt : retry_cnt + 2'd1;

  // The shared counter restarts on every transition and counts edges spent in
  // the current state; only WAIT_PG, LDO_ON and HICCUP look at it.
  always_ff @(posedge clk or posedge por) begin
    if (por) begin
      state     <= S_OFF;
      cnt       <= '0;
      retry_cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
      if (!sw_sig) begin
        // Switch-off wins over any simultaneous fault.
        if (state != S_OFF) begin
          state <= S_OFF;
          cnt   <= '0;
        end
        retry_cnt <= '0;
      end else if (fault) begin
        retry_cnt <= retry_next;
        state     <= (retry_next == RETRY_MAX) ? S_LATCHED : S_HICCUP;
        cnt       <= '0;
      end else begin
        case (state)
          S_OFF: begin
            state <= S_SOFTSTART;
            cnt   <= '0;
          end
          S_SOFTSTART: begin
            if (ramp_done) begin
              state <= S_WAIT_PG;
              cnt   <= '0;
            end
          end
          S_WAIT_PG: begin
            if (buck_pgood) begin
              state <= S_LDO_ON;
              cnt   <= '0;
            end
          end
          S_LDO_ON: begin
            if (cnt == LDO_LAST) begin
              state <= S_RUN;
              cnt   <= '0;
            end
          end
          S_HICCUP: begin
            if (cnt == HIC_LAST) begin
              state <= S_SOFTSTART;
              cnt   <= '0;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign rails         = decode_rails(state);
  assign buck_en       = rails.buck_en;
  assign ldo_en        = rails.ldo_en;
  assign pwr_good      = rails.pwr_good;
  assign fault_latched = rails.fault_latched;
  assign pwr_dis       = ~rails.buck_en;
  assign duty_limit    = (state == S_SOFTSTART) ? ramp_duty
                       : (rails.buck_en ? DUTY_MAX : '0);

endmodule

// File: tb/tb_power_sequencer.sv
// Bench for power_sequencer: phase/time model checked every cycle plus
// directed scenarios with hand-computed timing and status expectations.
module tb_power_sequencer;

  localparam int DUTY_MAX = 15;
  localparam int STEP     = 4;
  localparam int PG_TO    = 32;
  localparam int LDO_D    = 8;
  localparam int HIC      = 16;
  localparam int MAXR     = 3;

  localparam int C_DUTY_FULL = 0;
  localparam int C_LDO_ON    = 1;
  localparam int C_PWR_GOOD  = 2;
  localparam int C_BUCK_ON   = 3;
  localparam int C_BUCK_OFF  = 4;

  logic       clk = 1'b0;
  logic       por, sw_sig, ocp_trigger, buck_pgood;
  logic       buck_en, ldo_en, pwr_good, pwr_dis, fault_latched;
  logic [3:0] duty_limit;
  logic [1:0] retry_cnt;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  typedef enum {P_OFF, P_RAMP, P_PG, P_LDO, P_RUN, P_HIC, P_LATCH} phase_e;
  phase_e m_phase   = P_OFF;
  int     m_t       = 0;
  int     m_retries = 0;

  power_sequencer dut (
    .clk           (clk),
    .por           (por),
    .sw_sig        (sw_sig),
    .ocp_trigger   (ocp_trigger),
    .buck_pgood    (buck_pgood),
    .buck_en       (buck_en),
    .duty_limit    (duty_limit),
    .ldo_en        (ldo_en),
    .pwr_good      (pwr_good),
    .pwr_dis       (pwr_dis),
    .fault_latched (fault_latched),
    .retry_cnt     (retry_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Phase model: each phase lasts a fixed number of edges or until its exit
  // condition; m_t counts edges since the phase was entered.
  task automatic model_step();
    phase_e nxt;
    bit     flt;
    if (por) begin
      m_phase   = P_OFF;
      m_t       = 0;
      m_retries = 0;
      return;
    end
    nxt = m_phase;
    flt = 1'b0;
    if (!sw_sig) begin
      nxt       = P_OFF;
      m_retries = 0;
    end else begin
      case (m_phase)
        P_OFF:  nxt = P_RAMP;
        P_RAMP: if (ocp_trigger) flt = 1'b1;
                else if (m_t + 1 == DUTY_MAX * STEP) nxt = P_PG;
        P_PG:   if (ocp_trigger) flt = 1'b1;
                else if (buck_pgood) nxt = P_LDO;
                else if (m_t + 1 == PG_TO) flt = 1'b1;
        P_LDO:  if (ocp_trigger || !buck_pgood) flt = 1'b1;
                else if (m_t + 1 == LDO_D) nxt = P_RUN;
        P_RUN:  if (ocp_trigger || !buck_pgood) flt = 1'b1;
        P_HIC:  if (m_t + 1 == HIC) nxt = P_RAMP;
        default: ;
      endcase
    end
    if (flt) begin
      m_retries = (m_retries < MAXR) ? m_retries + 1 : MAXR;
      nxt = (m_retries == MAXR) ? P_LATCH : P_HIC;
    end
    if (nxt != m_phase) m_t = 0;
    else m_t++;
    m_phase = nxt;
  endtask

  function automatic logic [10:0] model_vec();
    bit         b;
    logic [3:0] d;
    b = (m_phase == P_RAMP) || (m_phase == P_PG) || (m_phase == P_LDO) || (m_phase == P_RUN);
    d = (m_phase == P_RAMP) ? 4'(m_t / STEP) : (b ? 4'(DUTY_MAX) : 4'd0);
    return {2'(m_retries), m_phase == P_LATCH, !b, m_phase == P_RUN,
            (m_phase == P_LDO) || (m_phase == P_RUN), b, d};
  endfunction

  function automatic logic [10:0] dut_vec();
    return {retry_cnt, fault_latched, pwr_dis, pwr_good, ldo_en, buck_en, duty_limit};
  endfunction

  initial begin
    forever begin
      @(posedge clk);
      model_step();
      #1;
      cyc++;
      check($sformatf("cycle %0d outputs", cyc), 32'(dut_vec()), 32'(model_vec()));
    end
  end

  function automatic bit cond(input int which);
    case (which)
      C_DUTY_FULL: return duty_limit == 4'd15;
      C_LDO_ON:    return ldo_en;
      C_PWR_GOOD:  return pwr_good;
      C_BUCK_ON:   return buck_en;
      default:     return !buck_en;
    endcase
  endfunction

  task automatic cycles(input int k);
    repeat (k) @(negedge clk);
  endtask

  task automatic wait_cond(input string name, input int which, input int limit, output int n);
    n = 0;
    while (!cond(which) && n < limit) begin
      @(negedge clk);
      n++;
    end
    check({name, " reached"}, 32'(cond(which)), 1);
  endtask

  task automatic pulse_ocp();
    ocp_trigger = 1'b1;
    @(negedge clk);
    ocp_trigger = 1'b0;
  endtask

  initial begin
    int n;
    por = 1'b1; sw_sig = 1'b1; ocp_trigger = 1'b0; buck_pgood = 1'b0;

    // Reset holds everything off even with the switch on.
    cycles(3);
    check("reset buck_en", 32'(buck_en), 0);
    check("reset ldo_en", 32'(ldo_en), 0);
    check("reset pwr_dis", 32'(pwr_dis), 1);
    check("reset duty", 32'(duty_limit), 0);
    check("reset retry", 32'(retry_cnt), 0);
    por = 1'b0;
    cycles(1);
    check("start buck_en", 32'(buck_en), 1);
    check("start duty", 32'(duty_limit), 0);

    // Normal start: 60-cycle ramp, LDO one cycle after pgood, RUN 8 later.
    wait_cond("ramp full", C_DUTY_FULL, 200, n);
    check("softstart length", n, 60);
    buck_pgood = 1'b1;
    cycles(1);
    check("ldo after pgood", 32'(ldo_en), 1);
    wait_cond("run", C_PWR_GOOD, 50, n);
    check("ldo to pwr_good", n, 8);

    // OCP in RUN: one-cycle shutdown, 16-cycle hiccup, full restart.
    cycles(3);
    pulse_ocp();
    check("ocp buck_en", 32'(buck_en), 0);
    check("ocp ldo_en", 32'(ldo_en), 0);
    check("ocp retry", 32'(retry_cnt), 1);
    wait_cond("hiccup end", C_BUCK_ON, 100, n);
    check("hiccup length", n, 16);
    wait_cond("rerun", C_PWR_GOOD, 200, n);
    check("restart to run", n, 69);

    // Latch-off on the third fault, here during soft-start.
    cycles(2);
    pulse_ocp();
    check("second fault retry", 32'(retry_cnt), 2);
    wait_cond("second restart", C_BUCK_ON, 100, n);
    cycles(10);
    pulse_ocp();
    check("latched flag", 32'(fault_latched), 1);
    check("latched retry", 32'(retry_cnt), 3);
    check("latched buck_en", 32'(buck_en), 0);
    repeat (5) begin
      pulse_ocp();
      cycles(5);
    end
    check("still latched", 32'(fault_latched), 1);
    check("latched stays off", 32'(buck_en), 0);
    sw_sig = 1'b0;
    cycles(1);
    check("unlatch flag", 32'(fault_latched), 0);
    check("unlatch retry", 32'(retry_cnt), 0);
    sw_sig = 1'b1;
    cycles(1);
    check("new start buck_en", 32'(buck_en), 1);
    check("new start duty", 32'(duty_limit), 0);

    // Power-good timeout: HICCUP exactly 32 cycles after WAIT_PG entry.
    buck_pgood = 1'b0;
    wait_cond("ramp full 2", C_DUTY_FULL, 200, n);
    check("softstart length 2", n, 60);
    wait_cond("pg timeout", C_BUCK_OFF, 100, n);
    check("pg timeout length", n, 32);
    check("pg timeout retry", 32'(retry_cnt), 1);

    // Power-good loss in RUN, then switch-off racing an OCP pulse.
    buck_pgood = 1'b1;
    wait_cond("run 3", C_PWR_GOOD, 300, n);
    cycles(3);
    buck_pgood = 1'b0;
    cycles(1);
    buck_pgood = 1'b1;
    check("pg loss buck_en", 32'(buck_en), 0);
    check("pg loss ldo_en", 32'(ldo_en), 0);
    check("pg loss retry", 32'(retry_cnt), 2);
    wait_cond("run 4", C_PWR_GOOD, 300, n);
    cycles(2);
    sw_sig = 1'b0;
    ocp_trigger = 1'b1;
    cycles(1);
    ocp_trigger = 1'b0;
    check("sw beats ocp latch", 32'(fault_latched), 0);
    check("sw beats ocp retry", 32'(retry_cnt), 0);
    check("sw beats ocp buck", 32'(buck_en), 0);
    sw_sig = 1'b1;
    cycles(1);
    check("restart buck_en", 32'(buck_en), 1);
    cycles(20);
    sw_sig = 1'b0;
    cycles(1);
    check("sw off mid ramp duty", 32'(duty_limit), 0);
    check("sw off mid ramp buck", 32'(buck_en), 0);

    // Asynchronous reset mid-ramp.
    sw_sig = 1'b1;
    cycles(10);
    por = 1'b1;
    #1;
    check("async por buck_en", 32'(buck_en), 0);
    check("async por pwr_dis", 32'(pwr_dis), 1);
    check("async por duty", 32'(duty_limit), 0);
    @(negedge clk);
    por = 1'b0;
    cycles(1);
    check("post por start", 32'(buck_en), 1);
    cycles(2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/power_sequencer.md
# power_sequencer

Clocked supply sequencer for the 5 V buck + linear-regulator board. It sits between the user switch, the OCP comparator and the buck power-good comparator on one side, and the buck enable, buck PWM duty limit and LDO enable on the other. It ramps the buck with a soft-start duty limit, confirms buck power-good, then enables the LDO. On over-current or power-good loss it runs hiccup auto-retry and latches off after a bounded number of faults; a latched fault is cleared by cycling the switch.

## Interface
- DUTY_W, 4: width of duty_limit; full scale DUTY_MAX = 2^DUTY_W-1.
- STEP_CYCLES, 4: clocks per soft-start duty increment (>=1).
- PG_TIMEOUT, 32: clocks allowed in WAIT_PG for buck_pgood.
- LDO_DELAY, 8: clocks from ldo_en rise to RUN.
- HICCUP_CYCLES, 16: off-time before a retry.
- MAX_RETRIES, 3: faults tolerated before latch-off (>=1).
- clk  in  1  system clock; the only clock.
- por  in  1  power-on reset, asynchronous, active-high.
- sw_sig  in  1  user enable switch, already synchronous to clk.
- ocp_trigger  in  1  over-current comparator, level, synchronous to clk.
- buck_pgood  in  1  buck output-in-regulation comparator, synchronous.
- buck_en  out  1  buck converter enable.
- duty_limit  out  DUTY_W  max PWM duty allowed to the buck modulator.
- ldo_en  out  1  linear-regulator enable.
- pwr_good  out  1  high only in RUN.
- pwr_dis  out  1  equals ~buck_en.
- fault_latched  out  1  high only in LATCHED.
- retry_cnt  out  2  faults since last OFF (status).

## Operation
- States: OFF, SOFTSTART, WAIT_PG, LDO_ON, RUN, HICCUP, LATCHED.
- OFF: all enables 0, duty_limit 0, retry_cnt cleared. sw_sig=1 -> SOFTSTART.
- SOFTSTART: buck_en=1. duty_limit starts at 0 and increments by 1 every STEP_CYCLES clocks. Reaching DUTY_MAX -> WAIT_PG.
- WAIT_PG: buck_en=1, duty_limit=DUTY_MAX. buck_pgood=1 -> LDO_ON. PG_TIMEOUT clocks without it -> fault.
- LDO_ON: buck_en and ldo_en=1. After LDO_DELAY clocks -> RUN. buck_pgood=0 -> fault.
- RUN: buck_en, ldo_en and pwr_good=1. buck_pgood=0 -> fault.
- Fault, from SOFTSTART/WAIT_PG/LDO_ON/RUN on ocp_trigger=1 or the conditions above: retry_cnt+1. If the new count equals MAX_RETRIES -> LATCHED, else -> HICCUP.
- HICCUP: all enables 0, duty_limit 0. After HICCUP_CYCLES clocks -> SOFTSTART from duty 0.
- LATCHED: all enables 0. Retries stop; the block stays here until sw_sig=0 -> OFF. ocp_trigger is ignored.
- sw_sig=0 in any state -> OFF. This beats a simultaneous fault, so retry_cnt is not incremented.
- ocp_trigger is ignored in OFF and HICCUP.
- retry_cnt saturates at MAX_RETRIES and clears only in OFF.
- Counters reset on every state entry.

## Timing
- por asserted: immediately state OFF. All outputs are 0 except pwr_dis=1; retry_cnt=0. This holds mid-ramp or mid-fault.
- Every output is a register or a pure decode of registers. Inputs sampled at edge N change outputs right after edge N; no combinational path from input to output.
- ocp_trigger high at edge N: buck_en=0 and ldo_en=0 after edge N (1-cycle shutdown).
- Soft-start lasts DUTY_MAX*STEP_CYCLES clocks (60 with defaults).
- Soft-start duty ramp: duty_limit=k holds STEP_CYCLES clocks.
- HICCUP, LDO_ON and WAIT_PG-timeout counts are exact, counted from the entry edge.

## Structure
- Shared package power_seq_pkg: state encodings (3-bit localparams) and default parameter constants, for reuse by the bench and powerController integration.
- One sub-module, soft_start_ramp: STEP_CYCLES prescaler plus saturating DUTY_W counter. Inputs clk, por, clear, run; outputs duty, done.
- The top level holds the FSM, one shared timeout/delay counter and retry_cnt.

## Test plan
- Reset: por=1 with sw_sig=1 -> all enables 0, pwr_dis=1, retry_cnt=0. por=0 -> SOFTSTART next edge.
- Normal start (defaults): sw_sig=1, buck_pgood rises at duty 15 -> duty 0..15 stepping every 4 clocks, ldo_en at WAIT_PG+1, pwr_good exactly 8 clocks after ldo_en.
- OCP in RUN: one-cycle ocp_trigger -> buck_en and ldo_en low next cycle, retry_cnt=1. Restart after 16 clocks, then reaches RUN again.
- Latch-off: three OCP pulses across retries -> fault_latched=1, retry_cnt=3. Further sw_sig=1 stays latched; sw_sig 0 then 1 -> OFF, retry_cnt=0, new soft-start.
- PG timeout: buck_pgood held 0 -> HICCUP exactly 32 clocks after WAIT_PG entry, retry_cnt=1.
- Simultaneous events: sw_sig=0 and ocp_trigger=1 on the same edge in RUN -> OFF, retry_cnt=0. sw_sig=0 mid-soft-start -> duty_limit 0 next cycle.
